// File: rtl/outputport.sv
// Router output port: registers one crossbar flit per cycle onto the link (1-cycle latency), tracking per-VC credits and packet ownership.
// Backpressure: flit_ready drops when the target VC has no credit or the flit breaks packet order; refused flits are dropped, never buffered.
module outputport #(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_VC     = 5,
    parameter  int VC_DEPTH   = 5,
    localparam int CNT_W      = $clog2(VC_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] flit_in,
    input  logic                  flit_valid,
    input  logic [NUM_VC-1:0]     flit_vc,
    input  logic                  flit_head,
    input  logic                  flit_tail,
    output logic                  flit_ready,
    input  logic [NUM_VC-1:0]     credit_in,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic [NUM_VC-1:0]     vcx_out,
    output logic [NUM_VC-1:0]     credit_avail,
    output logic [NUM_VC-1:0]     vc_busy,
    output logic                  err
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} vc_state_t;

    vc_state_t             r_state     [NUM_VC];
    vc_state_t             w_state_nxt [NUM_VC];
    logic [CNT_W-1:0]      r_credit    [NUM_VC];
    logic [CNT_W-1:0]      w_credit_nxt[NUM_VC];
    logic [DATA_WIDTH-1:0] r_flit_out;
    logic [NUM_VC-1:0]     r_vcx_out;
    logic                  r_err;

    logic [NUM_VC-1:0]     w_credit_nz;
    logic [NUM_VC-1:0]     w_ovf;
    logic [NUM_VC-1:0]     w_acc_vec;
    logic                  w_onehot;
    logic                  w_sel_credit;
    logic                  w_sel_busy;
    logic                  w_state_ok;
    logic                  w_err_set;

    // A head may only open an idle VC; anything else must continue an owned one.
    assign w_onehot     = (flit_vc != '0) && ((flit_vc & (flit_vc - NUM_VC'(1))) == '0);
    assign w_sel_credit = |(flit_vc & w_credit_nz);
    assign w_sel_busy   = |(flit_vc & vc_busy);
    assign w_state_ok   = w_sel_busy ? ~flit_head : flit_head;
    assign flit_ready   = flit_valid & w_onehot & w_sel_credit & w_state_ok;
    assign w_acc_vec    = {NUM_VC{flit_ready}} & flit_vc;
    assign w_err_set    = (flit_valid & ~w_onehot)
                        | (flit_valid & w_onehot & ~w_state_ok)
                        | (|w_ovf);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VC; i++) r_state[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_VC; i++) r_state[i] <= w_state_nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_acc_vec[i]) begin
                case (r_state[i])
                    S_IDLE:   if (flit_head && !flit_tail) w_state_nxt[i] = S_ACTIVE;
                    S_ACTIVE: if (flit_tail) w_state_nxt[i] = S_IDLE;
                    default:  w_state_nxt[i] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_busy[i] = (r_state[i] == S_ACTIVE);
        end
    end

    // A return with no send at full depth is an overflow; the counter saturates.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            w_ovf[i]        = 1'b0;
            w_credit_nxt[i] = r_credit[i];
            w_credit_nz[i]  = (r_credit[i] != '0);
            if (credit_in[i] && !w_acc_vec[i]) begin
                if (r_credit[i] == CNT_W'(VC_DEPTH)) w_ovf[i] = 1'b1;
                else                                 w_credit_nxt[i] = r_credit[i] + CNT_W'(1);
            end else if (!credit_in[i] && w_acc_vec[i]) begin
                w_credit_nxt[i] = r_credit[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VC; i++) r_credit[i] <= CNT_W'(VC_DEPTH);
            r_flit_out <= '0;
            r_vcx_out  <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) r_credit[i] <= w_credit_nxt[i];
            if (flit_ready) r_flit_out <= flit_in;
            r_vcx_out <= w_acc_vec;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign flit_out     = r_flit_out;
    assign vcx_out      = r_vcx_out;
    assign credit_avail = w_credit_nz;
    assign err          = r_err;

endmodule
